paralelo_serial_param: RTL and testbench
========================================

PARALELO_SERIAL_PARAM -- requirements
Module: paralelo_serial_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = serialize from bit WIDTH-1 down to bit 0; 0 = serialize from bit 0 up.
REQ-003 The block SHALL have parameter IDLE_WORD, default 8'hBC (WIDTH bits): the word transmitted when no data is available.
REQ-004 The block SHALL have port dclk, input, 1 bit: the single clock, serial bit rate; all state changes on its rising edge.
REQ-005 The block SHALL have port default_values, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port valid, input, 1 bit: data_in carries a word to send.
REQ-007 The block SHALL have port data_in, input, WIDTH bits: parallel word.
REQ-008 The block SHALL have port ready, output, 1 bit: block can accept a word this cycle.
REQ-009 The block SHALL have port data_out, output, 1 bit: serial bit stream.
REQ-010 The block SHALL have port frame_start, output, 1 bit: high while data_out carries the first bit of a word.
REQ-011 The block SHALL have port sending_data, output, 1 bit: high while the word on data_out came from data_in, low while it is IDLE_WORD.

Function
REQ-012 State: shift register sh (WIDTH), bit counter cnt (0..WIDTH-1), holding register hold (WIDTH), flag hold_full, flag sending_data.
REQ-013 Handshake: a word is accepted on any rising edge where valid=1 and ready=1; ready SHALL equal !hold_full (combinational); valid with ready=0 is ignored, with no stall or error.
REQ-014 A cycle with cnt==WIDTH-1 is a boundary; on its edge, next word source priority: (1) hold if hold_full, clearing hold_full; (2) data_in if accepted on that same edge (bypass, hold untouched); (3) IDLE_WORD.
REQ-015 On a boundary edge: sh <= selected word, cnt <= 0, sending_data <= 1 for sources (1)/(2), 0 for (3).
REQ-016 On a non-boundary edge: cnt <= cnt+1, sh shifts by one toward the output end (left if MSB_FIRST=1, right if 0), sending_data unchanged.
REQ-017 A word accepted on a non-boundary edge SHALL be written to hold and set hold_full; ready is low from the next cycle.
REQ-018 data_out SHALL be sh[WIDTH-1] when MSB_FIRST=1, sh[0] when MSB_FIRST=0; frame_start SHALL be (cnt==0) gated by "not in reset-first-cycle" per REQ-022.
REQ-019 Latency: a word accepted on a boundary edge with hold empty SHALL put its first bit on data_out in the immediately following cycle; a word in hold SHALL start at the next boundary.
REQ-020 Continuous valid=1 SHALL produce a gapless stream of consecutive data words with no IDLE_WORD between them.
REQ-021 Bits of each word SHALL appear for exactly WIDTH consecutive cycles; frame_start pulses exactly once per WIDTH cycles, every word (data or idle).

Reset
REQ-022 While default_values=1: sh=0, cnt=WIDTH-1, hold=0, hold_full=0, sending_data=0, frame_start=0, data_out=0, ready=1; the first edge after release is a boundary.
REQ-023 Assertion of default_values mid-word SHALL take effect immediately (asynchronous), discarding the word in sh and any word in hold.
REQ-024 A valid on the first edge after release SHALL be accepted via bypass (REQ-014 source 2).

Verification (WIDTH=8, IDLE_WORD=8'hBC unless noted)
REQ-025 Reset, valid=0 for 32 cycles -> data_out repeats 1,0,1,1,1,1,0,0 four times, frame_start every 8th cycle, sending_data=0.
REQ-026 valid=1, data_in=8'hFF on a boundary edge only -> next 8 cycles data_out=1 with sending_data=1, then BC pattern with sending_data=0.
REQ-027 valid=1 held with data_in FF,DD,EE,CC advancing on each accept -> data_out is FF,DD,EE,CC back-to-back MSB-first (32 bits, no idle gap), then BC.
REQ-028 Word 8'hDD accepted at cnt=3 -> ready=0 until the boundary, DD transmitted starting the next frame_start, ready=1 one cycle after the boundary.
REQ-029 default_values pulsed at cnt=4 of a data word with hold_full=1 -> data_out=0 and ready=1 at once; after release only BC idle words are sent.
REQ-030 MSB_FIRST=0, WIDTH=16, IDLE_WORD=16'h0000, data_in=16'h0001 -> data_out = 1 then 15 zeros.

Source files
------------

// File: rtl/paralelo_serial_param.sv
// ============================================================================
// paralelo_serial_param
// ----------------------------------------------------------------------------
// Parallel-to-serial converter that sends a continuous bit stream at one bit
// per dclk cycle. Words are grouped into frames of WIDTH bits. When no data
// word is ready at a frame boundary, IDLE_WORD is sent in its place, so the
// line always carries framed words.
//
// A one-word holding register lets the producer hand over the next word at
// any point inside the current frame. A word offered exactly on a frame
// boundary while the holding register is empty skips the holding register
// and starts on the very next cycle.
//
// Parameters
//   WIDTH      : parallel word width in bits (2..32)
//   MSB_FIRST  : 1 = send bit WIDTH-1 first, 0 = send bit 0 first
//   IDLE_WORD  : word sent when no data word is available
//
// Ports
//   dclk           in   bit-rate clock, rising edge active
//   default_values in   asynchronous active-high reset
//   valid          in   data_in carries a word to send
//   data_in        in   parallel word (WIDTH bits)
//   ready          out  a word offered this cycle will be taken
//   data_out       out  serial bit stream
//   frame_start    out  high while data_out carries the first bit of a word
//   sending_data   out  high while the current word came from data_in
// ============================================================================
module paralelo_serial_param #(
    parameter int                 WIDTH     = 8,
    parameter int                 MSB_FIRST = 1,
    parameter logic [WIDTH-1:0]   IDLE_WORD = WIDTH'(8'hBC)
) (
    input  logic             dclk,
    input  logic             default_values,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             data_out,
    output logic             frame_start,
    output logic             sending_data
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sh_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic             sending_data_r;
    logic             frame_start_r;

    // Next-state values
    logic [WIDTH-1:0] sh_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] hold_nxt_s;
    logic             hold_full_nxt_s;
    logic             sending_data_nxt_s;
    logic             frame_start_nxt_s;

    // Handshake and frame position
    logic             accept_s;
    logic             boundary_s;

    // The holding register is the only back-pressure point, so ready is
    // simply "holding register empty".
    assign ready      = ~hold_full_r;
    assign accept_s   = valid & ~hold_full_r;
    assign boundary_s = (cnt_r == CNT_LAST);

    // Next-state logic: word selection at frame boundaries, shifting inside
    // a frame, and capture of early words into the holding register.
    always_comb begin
        sh_nxt_s           = sh_r;
        cnt_nxt_s          = cnt_r;
        hold_nxt_s         = hold_r;
        hold_full_nxt_s    = hold_full_r;
        sending_data_nxt_s = sending_data_r;
        frame_start_nxt_s  = 1'b0;

        if (boundary_s) begin
            cnt_nxt_s         = {CW{1'b0}};
            frame_start_nxt_s = 1'b1;
            if (hold_full_r) begin
                // A word waiting in hold always wins; ready is low here so
                // no new word can arrive on this edge.
                sh_nxt_s           = hold_r;
                hold_full_nxt_s    = 1'b0;
                sending_data_nxt_s = 1'b1;
            end else if (accept_s) begin
                // Bypass: the word goes straight into the shifter and hold
                // stays untouched.
                sh_nxt_s           = data_in;
                sending_data_nxt_s = 1'b1;
            end else begin
                sh_nxt_s           = IDLE_WORD;
                sending_data_nxt_s = 1'b0;
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            if (MSB_FIRST != 0) begin
                sh_nxt_s = {sh_r[WIDTH-2:0], 1'b0};
            end else begin
                sh_nxt_s = {1'b0, sh_r[WIDTH-1:1]};
            end
            if (accept_s) begin
                hold_nxt_s      = data_in;
                hold_full_nxt_s = 1'b1;
            end else begin
                hold_nxt_s      = hold_r;
                hold_full_nxt_s = hold_full_r;
            end
        end
    end

    // State register with asynchronous reset. The counter resets to its
    // last value so the first edge after release is a frame boundary.
    always_ff @(posedge dclk or posedge default_values) begin
        if (default_values) begin
            sh_r           <= {WIDTH{1'b0}};
            cnt_r          <= CNT_LAST;
            hold_r         <= {WIDTH{1'b0}};
            hold_full_r    <= 1'b0;
            sending_data_r <= 1'b0;
            frame_start_r  <= 1'b0;
        end else begin
            sh_r           <= sh_nxt_s;
            cnt_r          <= cnt_nxt_s;
            hold_r         <= hold_nxt_s;
            hold_full_r    <= hold_full_nxt_s;
            sending_data_r <= sending_data_nxt_s;
            frame_start_r  <= frame_start_nxt_s;
        end
    end

    // frame_start_r is set exactly on the edges that load cnt_r with zero,
    // so it tracks cnt_r==0 but stays low while reset holds cnt at its top.
    assign frame_start  = frame_start_r;
    assign sending_data = sending_data_r;
    assign data_out     = (MSB_FIRST != 0) ? sh_r[WIDTH-1] : sh_r[0];

endmodule

// File: tb/tb_paralelo_serial_param.sv
// ============================================================================
// Testbench for paralelo_serial_param.
// Main instance: WIDTH=8, MSB_FIRST=1, IDLE_WORD=8'hBC, checked every cycle
// against a frame/queue reference model. Second instance: WIDTH=16,
// MSB_FIRST=0, IDLE_WORD=16'h0000 for the LSB-first case.
// ============================================================================
module tb_paralelo_serial_param;

    logic        dclk = 1'b0;
    logic        default_values;
    logic        valid;
    logic [7:0]  data_in;
    logic        ready;
    logic        data_out;
    logic        frame_start;
    logic        sending_data;

    logic        rst2;
    logic        valid2;
    logic [15:0] data2;
    logic        ready2;
    logic        data_out2;
    logic        frame_start2;
    logic        sending_data2;

    always #5 dclk = ~dclk;

    paralelo_serial_param #(.WIDTH(8), .MSB_FIRST(1), .IDLE_WORD(8'hBC)) dut (
        .dclk(dclk), .default_values(default_values), .valid(valid),
        .data_in(data_in), .ready(ready), .data_out(data_out),
        .frame_start(frame_start), .sending_data(sending_data)
    );

    paralelo_serial_param #(.WIDTH(16), .MSB_FIRST(0), .IDLE_WORD(16'h0000)) dut2 (
        .dclk(dclk), .default_values(rst2), .valid(valid2),
        .data_in(data2), .ready(ready2), .data_out(data_out2),
        .frame_start(frame_start2), .sending_data(sending_data2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model (frames + pending-word queue) -------
    logic [7:0] pend[$];      // accepted words not yet on the line
    logic [7:0] cur;          // word currently on the line
    logic       cur_snd;      // cur came from data_in
    int         pos;          // bit position inside current frame
    logic       started;      // at least one edge since reset release

    logic [63:0] col;         // every observed data_out bit
    logic [31:0] dcol;        // observed bits while sending_data=1
    int          dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        cur     = 8'h00;
        cur_snd = 1'b0;
        pos     = 7;
        started = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] d, input logic acc);
        if (acc) pend.push_back(d);
        if (pos == 7) begin
            if (pend.size() > 0) begin
                cur     = pend.pop_front();
                cur_snd = 1'b1;
            end else begin
                cur     = 8'hBC;
                cur_snd = 1'b0;
            end
            pos = 0;
        end else begin
            pos = pos + 1;
        end
        started = 1'b1;
    endtask

    // One clock cycle: drive inputs, check ready, take the edge, check outputs.
    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        valid   = v;
        data_in = d;
        acc     = v && (pend.size() == 0);
        #1;
        chk("ready_pre", 32'(ready), 32'(pend.size() == 0));
        @(posedge dclk);
        model_edge(d, acc);
        #1;
        chk("data_out", 32'(data_out), 32'(started ? cur[7-pos] : 1'b0));
        chk("frame_start", 32'(frame_start), 32'(started && pos == 0));
        chk("sending_data", 32'(sending_data), 32'(cur_snd));
        chk("ready_post", 32'(ready), 32'(pend.size() == 0));
        col = {col[62:0], data_out};
        if (sending_data) begin
            dcol = {dcol[30:0], data_out};
            dcnt++;
        end
    endtask

    task automatic do_reset();
        default_values = 1'b1;
        valid          = 1'b0;
        #1;
        model_reset();
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_sending", 32'(sending_data), 32'd0);
        @(negedge dclk);
        default_values = 1'b0;
    endtask

    logic [7:0] words [4];
    logic       acc;
    int         idx;

    initial begin
        words[0] = 8'hFF; words[1] = 8'hDD; words[2] = 8'hEE; words[3] = 8'hCC;
        col = 64'd0; dcol = 32'd0; dcnt = 0;
        valid = 1'b0; data_in = 8'h00;
        rst2 = 1'b1; valid2 = 1'b0; data2 = 16'h0000;

        // Reset then 32 idle cycles: BC repeated four times.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 8'h00, acc);
        chk("idle_pattern", col[31:0], 32'hBCBCBCBC);

        // Single FF offered exactly on a boundary edge.
        chk("at_boundary", 32'(pos), 32'd7);
        step(1'b1, 8'hFF, acc);
        chk("ff_accepted", 32'(acc), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, acc);
        chk("ff_word", 32'(col[7:0]), 32'hFF);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, acc);
        chk("bc_after_ff", 32'(col[7:0]), 32'hBC);

        // Continuous valid: FF,DD,EE,CC back to back.
        dcnt = 0; idx = 0;
        for (int i = 0; i < 64 && idx < 4; i++) begin
            step(1'b1, words[idx], acc);
            if (acc) idx++;
        end
        chk("burst_all_accepted", 32'(idx), 32'd4);
        for (int i = 0; i < 40 && dcnt < 32; i++) step(1'b0, 8'h00, acc);
        chk("burst_bits", 32'(dcnt), 32'd32);
        chk("burst_stream", dcol, 32'hFFDDEECC);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, acc);
        chk("bc_after_burst", 32'(col[7:0]), 32'hBC);

        // DD accepted mid-frame at cnt=3: waits in hold until the boundary.
        for (int i = 0; i < 10 && pos != 2; i++) step(1'b0, 8'h00, acc);
        step(1'b1, 8'hDD, acc);
        chk("dd_accept_pos", 32'(pos), 32'd3);
        chk("dd_hold_ready", 32'(ready), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, acc);
        chk("dd_bits", 32'(dcnt), 32'd8);
        chk("dd_word", 32'(dcol[7:0]), 32'hDD);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), acc);
        end
        for (int i = 0; i < 24; i++) step(1'b0, 8'h00, acc);

        // Reset pulsed at cnt=4 of a data word with hold full.
        do_reset();
        step(1'b1, 8'h11, acc);
        step(1'b1, 8'h22, acc);
        for (int i = 0; i < 10 && pos != 4; i++) step(1'b0, 8'h00, acc);
        chk("mid_pos", 32'(pos), 32'd4);
        chk("mid_hold_full", 32'(ready), 32'd0);
        chk("mid_sending", 32'(sending_data), 32'd1);
        #2;
        default_values = 1'b1;
        #1;
        model_reset();
        chk("async_data_out", 32'(data_out), 32'd0);
        chk("async_ready", 32'(ready), 32'd1);
        chk("async_sending", 32'(sending_data), 32'd0);
        @(negedge dclk);
        default_values = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, acc);
        chk("post_rst_no_data", 32'(dcnt), 32'd0);
        chk("post_rst_idle", 32'(col[15:0]), 32'hBCBC);

        // Valid on the very first edge after release goes through bypass.
        do_reset();
        step(1'b1, 8'hA5, acc);
        chk("first_edge_accept", 32'(acc), 32'd1);
        chk("first_edge_sending", 32'(sending_data), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, acc);
        chk("first_edge_word", 32'(col[7:0]), 32'hA5);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, acc);

        // LSB-first, 16-bit instance: 0001 -> 1 then 15 zeros.
        @(negedge dclk);
        chk("w16_rst_out", 32'(data_out2), 32'd0);
        rst2   = 1'b0;
        valid2 = 1'b1;
        data2  = 16'h0001;
        #1;
        chk("w16_ready", 32'(ready2), 32'd1);
        @(posedge dclk);
        #1;
        valid2 = 1'b0;
        data2  = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            chk("w16_bit", 32'(data_out2), 32'(i == 0));
            chk("w16_frame", 32'(frame_start2), 32'(i == 0));
            chk("w16_sending", 32'(sending_data2), 32'd1);
            @(posedge dclk);
            #1;
        end
        chk("w16_idle_out", 32'(data_out2), 32'd0);
        chk("w16_idle_sending", 32'(sending_data2), 32'd0);
        chk("w16_idle_frame", 32'(frame_start2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
